// File: rtl/instr_boot_loader.sv
// ============================================================================
// instr_boot_loader: UART byte stream -> instruction RAM loader and core start
// Optional LOADER_CHECKSUM_EN adds a mod-256 checksum byte after the data.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module instr_boot_loader #(
  parameter int unsigned MAX_WORDS = 4096,
  parameter logic [7:0]  ACK_BYTE  = 8'hAA,
  parameter logic [7:0]  DONE_BYTE = 8'h55,
  parameter logic [7:0]  ERR_BYTE  = 8'hEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        wr_en_instr,
  output logic [31:0] addr_in_instr,
  output logic [31:0] data_in_instr,
  output logic        core_start,
  input  logic        core_end,
  output logic        busy,
  output logic        error
);

  typedef enum logic [3:0] {
    S_LEN     = 4'd0,
    S_DATA    = 4'd1,
    S_CSUM    = 4'd2,
    S_ACK     = 4'd3,
    S_RUN     = 4'd4,
    S_DONE_TX = 4'd5,
    S_HALT    = 4'd6,
    S_ERR_TX  = 4'd7,
    S_ERR     = 4'd8
  } state_e;

  localparam logic [31:0] C_MAX_LEN = 32'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] len_q, len_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        core_start_q, core_start_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  logic [31:0] w_word;
  logic [31:0] w_next_cnt;
  logic        w_tx_fire;

  // The incoming byte completes the word: earlier bytes sit in shift_q, LSB first.
  assign w_word     = {rx_data, shift_q};
  assign w_next_cnt = word_cnt_q + 32'd1;
  assign w_tx_fire  = tx_valid_q & tx_ready;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    wr_en_d      = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    core_start_d = core_start_q;
    error_d      = error_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif

    case (state_q)
      S_LEN: begin
        if (rx_valid) begin
          shift_d    = {rx_data, shift_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if ((w_word == 32'd0) || (w_word > C_MAX_LEN)) begin
              state_d    = S_ERR_TX;
              tx_valid_d = 1'b1;
              tx_data_d  = ERR_BYTE;
            end else begin
              len_d      = w_word;
              word_cnt_d = 32'd0;
              state_d    = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          shift_d    = {rx_data, shift_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = sum_q + rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            wr_en_d    = 1'b1;
            addr_d     = {word_cnt_q[29:0], 2'b00};
            data_d     = w_word;
            word_cnt_d = w_next_cnt;
            if (w_next_cnt == len_q) begin
`ifdef LOADER_CHECKSUM_EN
              state_d    = S_CSUM;
`else
              state_d    = S_ACK;
              tx_valid_d = 1'b1;
              tx_data_d  = ACK_BYTE;
`endif
            end
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (rx_valid) begin
          tx_valid_d = 1'b1;
          if (rx_data == sum_q) begin
            state_d   = S_ACK;
            tx_data_d = ACK_BYTE;
          end else begin
            state_d   = S_ERR_TX;
            tx_data_d = ERR_BYTE;
          end
        end
      end
`endif

      S_ACK: begin
        if (w_tx_fire) begin
          tx_valid_d   = 1'b0;
          core_start_d = 1'b1;
          state_d      = S_RUN;
        end
      end

      S_RUN: begin
        if (core_end) begin
          state_d    = S_DONE_TX;
          tx_valid_d = 1'b1;
          tx_data_d  = DONE_BYTE;
        end
      end

      S_DONE_TX: begin
        if (w_tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = S_HALT;
        end
      end

      S_ERR_TX: begin
        if (w_tx_fire) begin
          tx_valid_d = 1'b0;
          error_d    = 1'b1;
          state_d    = S_ERR;
        end
      end

      default: ;
    endcase

    busy_d = (state_d == S_LEN) || (state_d == S_DATA) ||
             (state_d == S_CSUM) || (state_d == S_ACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LEN;
      byte_cnt_q   <= 2'd0;
      shift_q      <= 24'd0;
      len_q        <= 32'd0;
      word_cnt_q   <= 32'd0;
      wr_en_q      <= 1'b0;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'd0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign wr_en_instr   = wr_en_q;
  assign addr_in_instr = addr_q;
  assign data_in_instr = data_q;
  assign core_start    = core_start_q;
  assign busy          = busy_q;
  assign error         = error_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_boot_loader.sv
// ============================================================================
// tb_instr_boot_loader: randomized load sequences against a scoreboard model
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_boot_loader;

  localparam int unsigned MAX_WORDS = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        tx_ready = 1'b1;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        wr_en_instr;
  logic [31:0] addr_in_instr;
  logic [31:0] data_in_instr;
  logic        core_start;
  logic        core_end = 1'b0;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] prog [0:MAX_WORDS-1];
  logic [31:0] last_wr_addr = 32'hFFFF_FFFF;

  instr_boot_loader dut (
    .clk           (clk),
    .rst           (rst),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .tx_ready      (tx_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .wr_en_instr   (wr_en_instr),
    .addr_in_instr (addr_in_instr),
    .data_in_instr (data_in_instr),
    .core_start    (core_start),
    .core_end      (core_end),
    .busy          (busy),
    .error         (error)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Monitor: every RAM write and every tx handshake must match the next expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en_instr) begin
        checks++;
        last_wr_addr = addr_in_instr;
        if (exp_wa.size() == 0) begin
          errors++;
          $display("FAIL ram_write: unexpected write addr=%h data=%h, required none", addr_in_instr, data_in_instr);
        end else begin
          logic [31:0] ea, ed;
          ea = exp_wa.pop_front();
          ed = exp_wd.pop_front();
          if (addr_in_instr !== ea || data_in_instr !== ed) begin
            errors++;
            $display("FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h", addr_in_instr, data_in_instr, ea, ed);
          end
        end
      end
      if (tx_valid && tx_ready) begin
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_byte: unexpected byte %h, required none", tx_data);
        end else begin
          logic [7:0] eb;
          eb = exp_tx.pop_front();
          if (tx_data !== eb) begin
            errors++;
            $display("FAIL tx_byte: got %h, required %h", tx_data, eb);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic idle_gap(input int gap_max);
    repeat ($urandom_range(gap_max, 0)) begin
      rx_data = 8'($urandom);
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    idle_gap(gap_max);
  endtask

  task automatic do_reset();
    check("pending_expectations", 64'(exp_wa.size() + exp_tx.size()), 64'd0);
    exp_wa.delete();
    exp_wd.delete();
    exp_tx.delete();
    rst      = 1'b1;
    rx_valid = 1'b0;
    core_end = 1'b0;
    tick();
    check("reset_ctrl", {wr_en_instr, tx_valid, tx_data, core_start, busy, error}, 64'd0);
    check("reset_ram_bus", {addr_in_instr, data_in_instr}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("busy_in_len", 64'(busy), 64'd1);
  endtask

  task automatic wait_tx(input int budget);
    int c;
    c = 0;
    while (exp_tx.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    check("tx_within_budget", 64'(exp_tx.size()), 64'd0);
    exp_tx.delete();
  endtask

  // Reference model: a header of N words is accepted iff 1 <= N <= MAX_WORDS;
  // each accepted word k lands at byte address 4k, then the status byte follows.
  task automatic load(input logic [31:0] n, input bit bad_csum, input int gap_max);
    bit         ok;
    logic [7:0] sum;
    logic [31:0] w;
    ok  = (n != 32'd0) && (n <= 32'(MAX_WORDS));
    sum = 8'd0;
    if (!ok) begin
      exp_tx.push_back(8'hEE);
    end else begin
`ifdef LOADER_CHECKSUM_EN
      exp_tx.push_back(bad_csum ? 8'hEE : 8'hAA);
      if (core_end && !bad_csum) exp_tx.push_back(8'h55);
`else
      exp_tx.push_back(8'hAA);
      if (core_end) exp_tx.push_back(8'h55);
`endif
    end
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gap_max);
    if (!ok) return;
    for (int k = 0; k < int'(n); k++) begin
      w = prog[k];
      exp_wa.push_back(32'(k) * 32'd4);
      exp_wd.push_back(w);
      for (int b = 0; b < 4; b++) begin
        sum = sum + w[8*b +: 8];
        rx_valid = 1'b1;
        rx_data  = w[8*b +: 8];
        tick();
        rx_valid = 1'b0;
        if (b == 3 && k < 4) check("write_latency", 64'(wr_en_instr), 64'd1);
        idle_gap(gap_max);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_csum ? sum + 8'd1 : sum, gap_max);
`endif
  endtask

  initial begin
    logic [31:0] n;

    // Reset state and the two-word example program.
    do_reset();
    prog[0] = 32'h0000_0513;
    prog[1] = 32'h0010_0093;
    load(32'd2, 1'b0, 0);
    wait_tx(50);
    tick();
    check("core_start_after_ack", 64'(core_start), 64'd1);
    check("busy_in_run", 64'(busy), 64'd0);

    // RUN: stray rx bytes write nothing; core_end yields exactly one DONE byte.
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1);
    core_end = 1'b1;
    exp_tx.push_back(8'h55);
    wait_tx(50);
    repeat (30) tick();
    check("halt_core_start", 64'(core_start), 64'd1);
    check("halt_tx_idle", 64'(tx_valid), 64'd0);
    core_end = 1'b0;

    // Rejected headers: zero and MAX_WORDS+1.
    do_reset();
    load(32'd0, 1'b0, 1);
    wait_tx(50);
    repeat (1000) tick();
    check("len0_error", 64'(error), 64'd1);
    check("len0_core_start", 64'(core_start), 64'd0);
    do_reset();
    load(32'(MAX_WORDS + 1), 1'b0, 1);
    wait_tx(50);
    repeat (20) tick();
    check("len_over_error", 64'(error), 64'd1);
    check("len_over_core_start", 64'(core_start), 64'd0);

    // Transmitter back-pressure during ACK.
    do_reset();
    tx_ready = 1'b0;
    prog[0] = $urandom;
    load(32'd1, 1'b0, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      check("stall_tx", {tx_valid, tx_data, core_start}, {1'b1, 8'hAA, 1'b0});
    end
    for (int i = 0; i < 20; i++) tick();
    check("stall_tx_end", {tx_valid, tx_data, core_start}, {1'b1, 8'hAA, 1'b0});
    tx_ready = 1'b1;
    wait_tx(10);
    tick();
    check("stall_core_start", 64'(core_start), 64'd1);

    // Reset after 5 of 8 data bytes, then a clean one-word load.
    do_reset();
    prog[0] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd2 : 8'd0, 0);
    exp_wa.push_back(32'd0);
    exp_wd.push_back(32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) send_byte((i < 4) ? prog[0][8*i +: 8] : 8'h77, 0);
    do_reset();
    prog[0] = 32'h0000_0513;
`ifdef LOADER_CHECKSUM_EN
    load(32'd1, 1'b1, 0);
    wait_tx(50);
    check("bad_csum_error", 64'(error), 64'd1);
    check("bad_csum_core_start", 64'(core_start), 64'd0);
    do_reset();
`endif
    load(32'd1, 1'b0, 0);
    wait_tx(50);
    tick();
    check("reload_core_start", 64'(core_start), 64'd1);

    // Randomized programs; odd iterations hold core_end high before RUN.
    for (int it = 0; it < 8; it++) begin
      do_reset();
      n = 32'($urandom_range(8, 1));
      for (int k = 0; k < int'(n); k++) prog[k] = $urandom;
      core_end = it[0];
      load(n, 1'b0, 3);
      wait_tx(100);
      repeat (10) tick();
      check("rand_core_start", 64'(core_start), 64'd1);
      check("rand_error", 64'(error), 64'd0);
    end
    core_end = 1'b0;

    // Largest accepted program.
    do_reset();
    for (int k = 0; k < int'(MAX_WORDS); k++) prog[k] = $urandom;
    load(32'(MAX_WORDS), 1'b0, 0);
    wait_tx(50);
    check("max_last_addr", 64'(last_wr_addr), 64'h3FFC);
    tick();
    check("max_core_start", 64'(core_start), 64'd1);

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
